unidade_controle_jogo: RTL and testbench

Moore control unit for the LED-memory game that drives every zera/conta/registra input of the game datapath (fluxo_dados).
- Consumes the datapath status flags.
- Sequences rounds in two phases: first the sequence is shown on the LEDs, then the player's moves are collected and compared.
- Reports the game outcome (hit, error, timeout) and exposes its state for debug.

---
 rtl/jogo_pkg.sv | 55 +++++
 rtl/unidade_controle_jogo.sv | 167 ++++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the LED-memory game: state codes, state width and outcome encoding.
package jogo_pkg;

  localparam int ESTADO_W_DEF = 5;

  localparam logic [4:0] S_INICIAL        = 5'd0;
  localparam logic [4:0] S_PREPARACAO     = 5'd1;
  localparam logic [4:0] S_INICIA_RODADA  = 5'd2;
  localparam logic [4:0] S_CARREGA_LED    = 5'd3;
  localparam logic [4:0] S_MOSTRA_LED     = 5'd4;
  localparam logic [4:0] S_PROXIMO_LED    = 5'd5;
  localparam logic [4:0] S_FIM_EXIBICAO   = 5'd6;
  localparam logic [4:0] S_ESPERA_JOGADA  = 5'd7;
  localparam logic [4:0] S_REGISTRA       = 5'd8;
  localparam logic [4:0] S_COMPARACAO     = 5'd9;
  localparam logic [4:0] S_PROXIMA_JOGADA = 5'd10;
  localparam logic [4:0] S_PROXIMA_RODADA = 5'd11;
  localparam logic [4:0] S_FIM_ACERTO     = 5'd12;
  localparam logic [4:0] S_FIM_ERRO       = 5'd13;
  localparam logic [4:0] S_FIM_TIMEOUT    = 5'd14;

  typedef enum logic [4:0] {
    INICIAL        = S_INICIAL,
    PREPARACAO     = S_PREPARACAO,
    INICIA_RODADA  = S_INICIA_RODADA,
    CARREGA_LED    = S_CARREGA_LED,
    MOSTRA_LED     = S_MOSTRA_LED,
    PROXIMO_LED    = S_PROXIMO_LED,
    FIM_EXIBICAO   = S_FIM_EXIBICAO,
    ESPERA_JOGADA  = S_ESPERA_JOGADA,
    REGISTRA       = S_REGISTRA,
    COMPARACAO     = S_COMPARACAO,
    PROXIMA_JOGADA = S_PROXIMA_JOGADA,
    PROXIMA_RODADA = S_PROXIMA_RODADA,
    FIM_ACERTO     = S_FIM_ACERTO,
    FIM_ERRO       = S_FIM_ERRO,
    FIM_TIMEOUT    = S_FIM_TIMEOUT
  } estado_t;

  // Outcome code driven onto the board LEDs by the top level.
  localparam logic [1:0] RES_NENHUM  = 2'd0;
  localparam logic [1:0] RES_ACERTO  = 2'd1;
  localparam logic [1:0] RES_ERRO    = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  function automatic logic [1:0] codifica_resultado(input logic acertou,
                                                    input logic errou,
                                                    input logic timeout);
    if (acertou)      return RES_ACERTO;
    else if (errou)   return RES_ERRO;
    else if (timeout) return RES_TIMEOUT;
    else              return RES_NENHUM;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore control unit of the LED-memory game; drives all datapath controls.
// Macro UNIDADE_CONTROLE_TIMEOUT_EN enables the move timeout (contaT / fimT / fim_timeout).
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int ESTADO_W = ESTADO_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                jogada_feita,
  input  logic                igual,
  input  logic                fimS,
  input  logic                fimJ,
  input  logic                fimT,
  input  logic                timerLedsFim,
  output logic                zeraC,
  output logic                contaC,
  output logic                zeraS,
  output logic                contaS,
  output logic                zeraR,
  output logic                registraR,
  output logic                zeraT,
  output logic                contaT,
  output logic                zeraD,
  output logic                registraD,
  output logic                zeraSM,
  output logic                registraSM,
  output logic                zeraM,
  output logic                registraM,
  output logic                zeraTLeds,
  output logic                contaTLeds,
  output logic                zera_display,
  output logic                show_display,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [ESTADO_W-1:0] db_estado
);

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  estado_t estado_q, estado_d;

  always_ff @(posedge clock) begin
    if (reset) estado_q <= INICIAL;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:        if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:     estado_d = INICIA_RODADA;
      INICIA_RODADA:  estado_d = CARREGA_LED;
      CARREGA_LED:    estado_d = MOSTRA_LED;
      MOSTRA_LED: begin
        if (timerLedsFim) estado_d = fimS ? FIM_EXIBICAO : PROXIMO_LED;
      end
      PROXIMO_LED:    estado_d = CARREGA_LED;
      FIM_EXIBICAO:   estado_d = ESPERA_JOGADA;
      // A key press in the same cycle as the timeout still counts as a move.
      ESPERA_JOGADA: begin
        if (jogada_feita)             estado_d = REGISTRA;
        else if (fimT && TIMEOUT_EN)  estado_d = FIM_TIMEOUT;
      end
      REGISTRA:       estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     estado_d = FIM_ERRO;
        else if (fimS)  estado_d = fimJ ? FIM_ACERTO : PROXIMA_RODADA;
        else            estado_d = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
      PROXIMA_RODADA: estado_d = INICIA_RODADA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      default:        estado_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraC        = 1'b0;
    contaC       = 1'b0;
    zeraS        = 1'b0;
    contaS       = 1'b0;
    zeraR        = 1'b0;
    registraR    = 1'b0;
    zeraT        = 1'b0;
    contaT       = 1'b0;
    zeraD        = 1'b0;
    registraD    = 1'b0;
    zeraSM       = 1'b0;
    registraSM   = 1'b0;
    zeraM        = 1'b0;
    registraM    = 1'b0;
    zeraTLeds    = 1'b0;
    contaTLeds   = 1'b0;
    zera_display = 1'b0;
    show_display = 1'b0;
    pronto       = 1'b0;
    acertou      = 1'b0;
    errou        = 1'b0;
    timeout      = 1'b0;
    case (estado_q)
      PREPARACAO: begin
        zeraC        = 1'b1;
        zeraS        = 1'b1;
        zeraR        = 1'b1;
        zeraM        = 1'b1;
        zeraT        = 1'b1;
        zeraTLeds    = 1'b1;
        zera_display = 1'b1;
        registraD    = 1'b1;
        registraSM   = 1'b1;
      end
      INICIA_RODADA: begin
        zeraC     = 1'b1;
        zeraTLeds = 1'b1;
      end
      CARREGA_LED:    registraM  = 1'b1;
      MOSTRA_LED:     contaTLeds = 1'b1;
      PROXIMO_LED: begin
        contaC    = 1'b1;
        zeraTLeds = 1'b1;
      end
      FIM_EXIBICAO: begin
        zeraC = 1'b1;
        zeraT = 1'b1;
        zeraM = 1'b1;
      end
      ESPERA_JOGADA:  contaT = TIMEOUT_EN;
      REGISTRA: begin
        registraR = 1'b1;
        zeraT     = 1'b1;
      end
      PROXIMA_JOGADA: contaC = 1'b1;
      PROXIMA_RODADA: begin
        contaS = 1'b1;
        zeraR  = 1'b1;
      end
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = TIMEOUT_EN;
      end
      default: ;
    endcase
    // Unused codes fall outside this range, so they keep the display off too.
    show_display = (estado_q >= INICIA_RODADA) && (estado_q <= FIM_TIMEOUT);
  end

  assign db_estado = ESTADO_W'(estado_q);

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: directed state walk plus random games played
// against a counter-level datapath model and an outcome/LED/move-count scoreboard.
module tb_unidade_controle_jogo;

  logic clock = 1'b0;
  logic reset, iniciar, jogada_feita, igual, fimS, fimJ, fimT, timerLedsFim;
  logic zeraC, contaC, zeraS, contaS, zeraR, registraR, zeraT, contaT;
  logic zeraD, registraD, zeraSM, registraSM, zeraM, registraM, zeraTLeds, contaTLeds;
  logic zera_display, show_display, pronto, acertou, errou, timeout;
  logic [4:0] db_estado;
  logic [21:0] all_outs;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam logic TEN = 1'b1;
`else
  localparam logic TEN = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  unidade_controle_jogo #(.ESTADO_W(5)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .fimS(fimS), .fimJ(fimJ), .fimT(fimT), .timerLedsFim(timerLedsFim),
    .zeraC(zeraC), .contaC(contaC), .zeraS(zeraS), .contaS(contaS), .zeraR(zeraR),
    .registraR(registraR), .zeraT(zeraT), .contaT(contaT), .zeraD(zeraD),
    .registraD(registraD), .zeraSM(zeraSM), .registraSM(registraSM), .zeraM(zeraM),
    .registraM(registraM), .zeraTLeds(zeraTLeds), .contaTLeds(contaTLeds),
    .zera_display(zera_display), .show_display(show_display), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  assign all_outs = {zeraC, contaC, zeraS, contaS, zeraR, registraR, zeraT, contaT,
                     zeraD, registraD, zeraSM, registraSM, zeraM, registraM, zeraTLeds,
                     contaTLeds, zera_display, show_display, pronto, acertou, errou, timeout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From preparacao, run a one-LED display straight to espera_jogada.
  task automatic go_espera();
    timerLedsFim = 1'b1;
    fimS = 1'b1;
    repeat (5) tick();
    timerLedsFim = 1'b0;
    check("to_espera", db_estado, 7);
  endtask

  // One game: last round index j-1; optional wrong move at (er, em).
  task automatic play_game(input int j, input bit has_err, input int er, input int em);
    int c_c, c_s, c_tl, n_leds, n_moves, exp_leds, exp_moves, cyc;
    logic [31:0] exp_res;
    bit done;
    exp_res = has_err ? 32'd2 : 32'd1;
    if (has_err) begin
      exp_moves = er * (er + 1) / 2 + em + 1;
      exp_leds  = (er + 1) * (er + 2) / 2;
    end else begin
      exp_moves = j * (j + 1) / 2;
      exp_leds  = exp_moves;
    end
    exp_q.push_back(exp_res);
    exp_q.push_back(exp_leds);
    exp_q.push_back(exp_moves);
    c_c = 0; c_s = 0; c_tl = 0; n_leds = 0; n_moves = 0; done = 0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (cyc = 0; cyc < 600; cyc++) begin
      if (zeraC) c_c = 0; else if (contaC) c_c++;
      if (zeraS) c_s = 0; else if (contaS) c_s++;
      if (zeraTLeds) c_tl = 0; else if (contaTLeds) c_tl++;
      if (registraM) n_leds++;
      if (registraR) n_moves++;
      fimS = (c_c == c_s);
      fimJ = (c_s == j - 1);
      igual = !(has_err && c_s == er && c_c == em);
      timerLedsFim = (c_tl >= 2);
      jogada_feita = ($urandom_range(0, 2) == 0);
      iniciar = ($urandom_range(0, 3) == 0);
      if (pronto) begin
        done = 1;
        break;
      end
      tick();
    end
    iniciar = 1'b0;
    jogada_feita = 1'b0;
    timerLedsFim = 1'b0;
    check("game_budget", done, 1);
    check("game_result", {30'd0, acertou, errou} == 2'b10 ? 1 :
                         ({acertou, errou} == 2'b01 ? 2 : 0), exp_q.pop_front());
    check("game_leds", n_leds, exp_q.pop_front());
    check("game_moves", n_moves, exp_q.pop_front());
    check("game_timeout_flag", timeout, 0);
    if (!done) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end
  endtask

  initial begin
    int m_cnt;
    reset = 1'b1; iniciar = 0; jogada_feita = 0; igual = 0; fimS = 0; fimJ = 0;
    fimT = 0; timerLedsFim = 0;
    tick(); tick();
    check("reset_state", db_estado, 0);
    check("reset_outs", all_outs, 0);

    reset = 1'b0; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("prep_state", db_estado, 1);
    check("prep_zeraC", zeraC, 1);
    check("prep_registraD", registraD, 1);
    check("prep_show", show_display, 0);

    fimS = 1'b1; m_cnt = 0;
    tick(); m_cnt += int'(registraM);
    check("inicia_state", db_estado, 2);
    check("inicia_show", show_display, 1);
    tick(); m_cnt += int'(registraM);
    check("carrega_state", db_estado, 3);
    tick(); m_cnt += int'(registraM);
    iniciar = 1'b1;
    repeat (4) begin tick(); m_cnt += int'(registraM); end
    check("mostra_hold_iniciar_ignored", db_estado, 4);
    check("mostra_contaTLeds", contaTLeds, 1);
    iniciar = 1'b0; timerLedsFim = 1'b1;
    tick(); m_cnt += int'(registraM);
    timerLedsFim = 1'b0;
    check("fim_exib_state", db_estado, 6);
    tick(); m_cnt += int'(registraM);
    check("espera_state", db_estado, 7);
    check("registraM_once", m_cnt, 1);

    igual = 1'b1; fimJ = 1'b1; jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0;
    check("registra_state", db_estado, 8);
    check("registra_registraR", registraR, 1);
    tick();
    check("comparacao_state", db_estado, 9);
    tick();
    check("acerto_state", db_estado, 12);
    check("acerto_flags", {pronto, acertou, errou, timeout}, 4'b1100);
    jogada_feita = 1'b1;
    repeat (3) tick();
    jogada_feita = 1'b0;
    check("acerto_held", {27'd0, db_estado}, 12);
    check("acerto_pronto_held", pronto, 1);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("restart_state", db_estado, 1);

    go_espera();
    fimS = 1'b0; fimJ = 1'b0; igual = 1'b1; jogada_feita = 1'b1;
    tick(); jogada_feita = 1'b0;
    tick(); tick();
    check("prox_jogada_state", db_estado, 10);
    check("prox_jogada_contaC", contaC, 1);
    tick();
    check("back_espera", db_estado, 7);
    check("back_espera_contaC", contaC, 0);
    fimS = 1'b1; jogada_feita = 1'b1;
    tick(); jogada_feita = 1'b0;
    tick(); tick();
    check("prox_rodada_state", db_estado, 11);
    check("prox_rodada_contaS", contaS, 1);
    tick();
    check("new_round_state", db_estado, 2);

    timerLedsFim = 1'b1;
    repeat (4) tick();
    timerLedsFim = 1'b0;
    check("round2_espera", db_estado, 7);
    igual = 1'b0; jogada_feita = 1'b1;
    tick(); jogada_feita = 1'b0;
    tick(); tick();
    check("erro_state", db_estado, 13);
    check("erro_flags", {pronto, acertou, errou, timeout}, 4'b1010);

    iniciar = 1'b1; tick(); iniciar = 1'b0;
    go_espera();
    check("espera_contaT", contaT, TEN);
    fimS = 1'b0; igual = 1'b1; fimT = 1'b1; jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0; fimT = 1'b0;
    check("priority_jogada", db_estado, 8);
    tick(); tick(); tick();
    check("timeout_setup", db_estado, 7);
    fimT = 1'b1;
    tick();
    fimT = 1'b0;
    if (TEN) begin
      check("timeout_state", db_estado, 14);
      check("timeout_flags", {pronto, acertou, errou, timeout}, 4'b1001);
    end else begin
      check("fimT_ignored", db_estado, 7);
      check("contaT_zero", contaT, 0);
    end

    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    reset = 1'b1; iniciar = 1'b1; jogada_feita = 1'b1;
    tick();
    reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0;
    check("midround_reset_state", db_estado, 0);
    check("midround_reset_outs", all_outs, 0);

    fimS = 0; fimJ = 0; igual = 0;
    for (int g = 0; g < 24; g++) begin
      int j, er, em;
      bit he;
      j  = $urandom_range(1, 4);
      he = ($urandom_range(0, 2) == 0);
      er = $urandom_range(0, j - 1);
      em = $urandom_range(0, er);
      play_game(j, he, er, em);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
